// File: rtl/salamander_frame_sig_if.sv
`default_nettype none
// ============================================================================
//  Module      : salamander_frame_sig_if
//  Description : Video-in / signature-out bundle for the frame signature unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface salamander_frame_sig_if #(
    parameter int PIXEL_W = 15,
    parameter int CNT_W   = 9
);
    logic               i_EMU_CLK6MPCEN_n;
    logic [CNT_W-1:0]   i_HCOUNTER;
    logic [CNT_W-1:0]   i_VCOUNTER;
    logic [PIXEL_W-1:0] i_VIDEODATA;
    logic [31:0]        o_SIG;
    logic               o_SIG_VALID;
    logic [31:0]        o_PIX_CNT;
    logic [15:0]        o_FRAME_CNT;
    logic               o_SEQ_ERR;
    logic               o_BUSY;

    modport master (
        output i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_VIDEODATA,
        input  o_SIG, o_SIG_VALID, o_PIX_CNT, o_FRAME_CNT, o_SEQ_ERR, o_BUSY
    );

    modport slave (
        input  i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_VIDEODATA,
        output o_SIG, o_SIG_VALID, o_PIX_CNT, o_FRAME_CNT, o_SEQ_ERR, o_BUSY
    );
endinterface
`default_nettype wire

// File: rtl/salamander_frame_sig.sv
`default_nettype none
// ============================================================================
//  Module      : salamander_frame_sig
//  Description : Per-frame CRC-32/MPEG-2 signature over an active video window.
//                Optional macro FRAME_SIG_LOG_EN adds simulation log output.
//  Revision    : 1.0  initial release
// ============================================================================
module salamander_frame_sig #(
    parameter int PIXEL_W     = 15,
    parameter int CNT_W       = 9,
    parameter int H_START     = 128,
    parameter int H_END       = 383,
    parameter int V_START     = 16,
    parameter int V_END       = 239,
    parameter int SKIP_FRAMES = 2
) (
    input  logic                  i_EMU_MCLK,
    input  logic                  i_MRST_n,
    salamander_frame_sig_if.slave bus
);

    localparam logic [31:0] c_CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] c_CRC_INIT = 32'hFFFF_FFFF;
    localparam int          c_SKIP_W   = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [c_SKIP_W-1:0] c_SKIP_LAST =
        c_SKIP_W'((SKIP_FRAMES > 0) ? (SKIP_FRAMES - 1) : 0);
    localparam logic [CNT_W-1:0] c_H_START = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] c_H_END   = CNT_W'(H_END);
    localparam logic [CNT_W-1:0] c_V_START = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] c_V_END   = CNT_W'(V_END);

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // With nothing to skip the unit is ready on the very first pixel cycle.
    localparam state_t c_RST_STATE = state_t'((SKIP_FRAMES == 0) ? ST_IDLE : ST_SKIP);

    // Bit-serial MSB-first CRC; unrolled by synthesis into the 32-bit parallel form.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc_in,
                                               input logic [31:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ c_CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t                state_q,     state_d;
    logic [c_SKIP_W-1:0]   skip_cnt_q,  skip_cnt_d;
    logic [31:0]           crc_q,       crc_d;
    logic [31:0]           pix_cnt_q,   pix_cnt_d;
    logic [31:0]           sig_q,       sig_d;
    logic                  sig_valid_q, sig_valid_d;
    logic [31:0]           pix_out_q,   pix_out_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  seq_err_q,   seq_err_d;
    logic [CNT_W-1:0]      prev_h_q,    prev_h_d;
    logic [CNT_W-1:0]      prev_v_q,    prev_v_d;
    logic                  prev_act_q,  prev_act_d;

    logic                  w_pix_cyc;
    logic [CNT_W-1:0]      w_h;
    logic [CNT_W-1:0]      w_v;
    logic [PIXEL_W-1:0]    w_pix;
    logic [31:0]           w_pix32;
    logic                  w_active;
    logic                  w_fs;
    logic                  w_fe;
    logic [CNT_W-1:0]      w_h_follow;
    logic                  w_seq_viol;
    logic [31:0]           w_crc_base;
    logic [31:0]           w_crc_upd;
    logic                  w_report;

    assign w_pix_cyc  = ~bus.i_EMU_CLK6MPCEN_n;
    assign w_h        = bus.i_HCOUNTER;
    assign w_v        = bus.i_VCOUNTER;
    assign w_pix      = bus.i_VIDEODATA;
    assign w_pix32    = 32'(w_pix);

    assign w_active   = (w_h >= c_H_START) && (w_h <= c_H_END) &&
                        (w_v >= c_V_START) && (w_v <= c_V_END);
    assign w_fs       = (w_h == c_H_START) && (w_v == c_V_START);
    assign w_fe       = (w_h == c_H_END)   && (w_v == c_V_END);

    // Only back-to-back active pixels on one line are expected to be contiguous.
    assign w_h_follow = prev_h_q + CNT_W'(1);
    assign w_seq_viol = prev_act_q && (w_v == prev_v_q) && (w_h != w_h_follow);

    assign w_crc_base = w_fs ? c_CRC_INIT : crc_q;
    assign w_crc_upd  = crc32_word(w_crc_base, w_pix32);

    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        crc_d       = crc_q;
        pix_cnt_d   = pix_cnt_q;
        sig_d       = sig_q;
        sig_valid_d = 1'b0;
        pix_out_d   = pix_out_q;
        frame_cnt_d = frame_cnt_q;
        seq_err_d   = seq_err_q;
        prev_h_d    = prev_h_q;
        prev_v_d    = prev_v_q;
        prev_act_d  = prev_act_q;
        w_report    = 1'b0;

        if (w_pix_cyc) begin
            prev_h_d   = w_h;
            prev_v_d   = w_v;
            prev_act_d = w_active;

            unique case (state_q)
                ST_SKIP: begin
                    if (w_fe) begin
                        skip_cnt_d = skip_cnt_q + c_SKIP_W'(1);
                        if (skip_cnt_q == c_SKIP_LAST) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_fs) begin
                        crc_d     = w_crc_upd;
                        pix_cnt_d = 32'd1;
                        // A 1x1 window starts and ends on the same pixel.
                        if (w_fe) begin
                            w_report = 1'b1;
                        end else begin
                            state_d  = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_fs) begin
                        seq_err_d = 1'b1;
                        crc_d     = w_crc_upd;
                        pix_cnt_d = 32'd1;
                    end else if (w_active) begin
                        crc_d     = w_crc_upd;
                        pix_cnt_d = pix_cnt_q + 32'd1;
                        if (w_seq_viol) begin
                            seq_err_d = 1'b1;
                        end
                        if (w_fe) begin
                            w_report = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = c_RST_STATE;
                end
            endcase

            if (w_report) begin
                sig_d       = crc_d;
                pix_out_d   = pix_cnt_d;
                frame_cnt_d = frame_cnt_q + 16'd1;
                sig_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state_q     <= c_RST_STATE;
            skip_cnt_q  <= '0;
            crc_q       <= c_CRC_INIT;
            pix_cnt_q   <= '0;
            sig_q       <= '0;
            sig_valid_q <= 1'b0;
            pix_out_q   <= '0;
            frame_cnt_q <= '0;
            seq_err_q   <= 1'b0;
            prev_h_q    <= '0;
            prev_v_q    <= '0;
            prev_act_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            crc_q       <= crc_d;
            pix_cnt_q   <= pix_cnt_d;
            sig_q       <= sig_d;
            sig_valid_q <= sig_valid_d;
            pix_out_q   <= pix_out_d;
            frame_cnt_q <= frame_cnt_d;
            seq_err_q   <= seq_err_d;
            prev_h_q    <= prev_h_d;
            prev_v_q    <= prev_v_d;
            prev_act_q  <= prev_act_d;
        end
    end

    assign bus.o_SIG       = sig_q;
    assign bus.o_SIG_VALID = sig_valid_q;
    assign bus.o_PIX_CNT   = pix_out_q;
    assign bus.o_FRAME_CNT = frame_cnt_q;
    assign bus.o_SEQ_ERR   = seq_err_q;
    assign bus.o_BUSY      = (state_q == ST_ACTIVE);

`ifdef FRAME_SIG_LOG_EN
    always @(posedge i_EMU_MCLK) begin
        if (sig_valid_q) begin
            $display("frame=%0d sig=%08h pix=%0d seqerr=%0b",
                     frame_cnt_q, sig_q, pix_out_q, seq_err_q);
        end
        if (i_MRST_n && seq_err_d && !seq_err_q) begin
            $display("salamander_frame_sig: warning, counter discontinuity at h=%0d v=%0d",
                     w_h, w_v);
        end
    end
`else
    // Synthesis builds carry no logging side channel.
`endif

endmodule
`default_nettype wire

// File: tb/tb_salamander_frame_sig.sv
`default_nettype none
// ============================================================================
//  Module      : tb_salamander_frame_sig
//  Description : Self-checking bench: two DUTs (reduced window, 1x1 window)
//                against a byte-wise CRC-32/MPEG-2 frame model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_salamander_frame_sig;

    localparam int PIXEL_W = 15;
    localparam int CNT_W   = 9;
    localparam int H_SPAN  = 32;
    localparam int V_SPAN  = 16;
    localparam int HS[2]   = '{10, 5};
    localparam int HE[2]   = '{25, 5};
    localparam int VS[2]   = '{4, 5};
    localparam int VE[2]   = '{11, 5};
    localparam int SKIPN[2] = '{2, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    salamander_frame_sig_if #(.PIXEL_W(PIXEL_W), .CNT_W(CNT_W)) bus_a ();
    salamander_frame_sig_if #(.PIXEL_W(16),      .CNT_W(CNT_W)) bus_b ();

    assign bus_b.i_EMU_CLK6MPCEN_n = bus_a.i_EMU_CLK6MPCEN_n;
    assign bus_b.i_HCOUNTER        = bus_a.i_HCOUNTER;
    assign bus_b.i_VCOUNTER        = bus_a.i_VCOUNTER;
    assign bus_b.i_VIDEODATA       = 16'h0000;

    salamander_frame_sig #(
        .PIXEL_W(PIXEL_W), .CNT_W(CNT_W), .H_START(10), .H_END(25),
        .V_START(4), .V_END(11), .SKIP_FRAMES(2)
    ) dut_a (
        .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .bus(bus_a)
    );

    salamander_frame_sig #(
        .PIXEL_W(16), .CNT_W(CNT_W), .H_START(5), .H_END(5),
        .V_START(5), .V_END(5), .SKIP_FRAMES(0)
    ) dut_b (
        .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] got, input logic [31:0] other);
        n_checks++;
        if (got === other) begin
            n_fail++;
            $display("FAIL %s: got %h expected a value different from %h", name, got, other);
        end
    endtask

    // Textbook byte-at-a-time CRC-32/MPEG-2.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            r = crc_byte(r, w[8*i +: 8]);
        end
        return r;
    endfunction

    // Frame model, one slot per DUT.
    logic [31:0] m_crc[2], m_cnt[2], e_sig[2], e_pix[2];
    logic [15:0] e_frame[2];
    bit          e_valid[2], e_seq[2], m_busy[2], m_prev_act[2];
    int          m_skips[2], m_prev_h[2], m_prev_v[2];

    always @(posedge clk or negedge rst_n) begin
        int          h, v;
        logic [31:0] d;
        bit          act, fs, fe;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_crc[k] = 32'hFFFF_FFFF; m_cnt[k] = 0; e_sig[k] = 0; e_pix[k] = 0;
                e_frame[k] = 0; e_valid[k] = 0; e_seq[k] = 0; m_busy[k] = 0;
                m_prev_act[k] = 0; m_skips[k] = 0; m_prev_h[k] = 0; m_prev_v[k] = 0;
            end else begin
                e_valid[k] = 0;
                if (bus_a.i_EMU_CLK6MPCEN_n == 1'b0) begin
                    h   = int'(bus_a.i_HCOUNTER);
                    v   = int'(bus_a.i_VCOUNTER);
                    d   = (k == 0) ? 32'(bus_a.i_VIDEODATA) : 32'(bus_b.i_VIDEODATA);
                    act = (h >= HS[k]) && (h <= HE[k]) && (v >= VS[k]) && (v <= VE[k]);
                    fs  = (h == HS[k]) && (v == VS[k]);
                    fe  = (h == HE[k]) && (v == VE[k]);
                    if (m_skips[k] < SKIPN[k]) begin
                        if (fe) m_skips[k]++;
                    end else if (fs) begin
                        if (m_busy[k]) e_seq[k] = 1;
                        m_crc[k]  = crc_word(32'hFFFF_FFFF, d);
                        m_cnt[k]  = 1;
                        m_busy[k] = 1;
                    end else if (m_busy[k] && act) begin
                        if (m_prev_act[k] && v == m_prev_v[k] &&
                            h != ((m_prev_h[k] + 1) % (1 << CNT_W)))
                            e_seq[k] = 1;
                        m_crc[k] = crc_word(m_crc[k], d);
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                    if (m_busy[k] && fe) begin
                        e_sig[k]   = m_crc[k];
                        e_pix[k]   = m_cnt[k];
                        e_frame[k] = e_frame[k] + 16'd1;
                        e_valid[k] = 1;
                        m_busy[k]  = 0;
                    end
                    m_prev_act[k] = act;
                    m_prev_h[k]   = h;
                    m_prev_v[k]   = v;
                end
            end
        end
    end

    logic [31:0] rep_sig[$], rep_pix[$], rep_frame[$], rep_seq[$];
    int          b_reps = 0;
    logic [31:0] b_last_sig, b_last_pix;

    always @(negedge clk) begin
        check("a.o_SIG",       bus_a.o_SIG,       e_sig[0]);
        check("a.o_SIG_VALID", 32'(bus_a.o_SIG_VALID), 32'(e_valid[0]));
        check("a.o_PIX_CNT",   bus_a.o_PIX_CNT,   e_pix[0]);
        check("a.o_FRAME_CNT", 32'(bus_a.o_FRAME_CNT), 32'(e_frame[0]));
        check("a.o_SEQ_ERR",   32'(bus_a.o_SEQ_ERR),   32'(e_seq[0]));
        check("a.o_BUSY",      32'(bus_a.o_BUSY),      32'(m_busy[0]));
        check("b.o_SIG",       bus_b.o_SIG,       e_sig[1]);
        check("b.o_SIG_VALID", 32'(bus_b.o_SIG_VALID), 32'(e_valid[1]));
        check("b.o_PIX_CNT",   bus_b.o_PIX_CNT,   e_pix[1]);
        check("b.o_FRAME_CNT", 32'(bus_b.o_FRAME_CNT), 32'(e_frame[1]));
        check("b.o_SEQ_ERR",   32'(bus_b.o_SEQ_ERR),   32'(e_seq[1]));
        check("b.o_BUSY",      32'(bus_b.o_BUSY),      32'(m_busy[1]));
        if (bus_a.o_SIG_VALID === 1'b1) begin
            rep_sig.push_back(bus_a.o_SIG);
            rep_pix.push_back(bus_a.o_PIX_CNT);
            rep_frame.push_back(32'(bus_a.o_FRAME_CNT));
            rep_seq.push_back(32'(bus_a.o_SEQ_ERR));
        end
        if (bus_b.o_SIG_VALID === 1'b1) begin
            b_reps++;
            b_last_sig = bus_b.o_SIG;
            b_last_pix = bus_b.o_PIX_CNT;
        end
    end

    // One pixel cycle per three MCLKs.
    task automatic drive_pix(input int h, input int v, input logic [PIXEL_W-1:0] d);
        @(negedge clk);
        bus_a.i_HCOUNTER        = CNT_W'(h);
        bus_a.i_VCOUNTER        = CNT_W'(v);
        bus_a.i_VIDEODATA       = d;
        bus_a.i_EMU_CLK6MPCEN_n = 1'b0;
        @(negedge clk);
        bus_a.i_EMU_CLK6MPCEN_n = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: zeros, 1: ramp h^v, 2: ramp with (17,7) flipped, 3: ramp with h=21 skipped on v=8
    task automatic drive_frame(input int mode, input int v_stop);
        logic [PIXEL_W-1:0] d;
        for (int v = 0; v < v_stop; v++) begin
            for (int h = 0; h < H_SPAN; h++) begin
                d = (mode == 0) ? '0 : PIXEL_W'(h ^ v);
                if (mode == 2 && h == 17 && v == 7) d = d ^ 15'h4001;
                if (!(mode == 3 && h == 21 && v == 8)) drive_pix(h, v, d);
            end
        end
    endtask

    initial begin
        logic [31:0] c, zero_sig, ramp_sig;
        int          base;

        bus_a.i_EMU_CLK6MPCEN_n = 1'b1;
        bus_a.i_HCOUNTER        = '0;
        bus_a.i_VCOUNTER        = '0;
        bus_a.i_VIDEODATA       = '0;

        c = 32'hFFFF_FFFF;
        for (int i = 1; i <= 9; i++) c = crc_byte(c, 8'(8'h30 + i));
        check("model check string", c, 32'h0376_E6E7);
        check("model zero word", crc_word(32'hFFFF_FFFF, 32'h0), 32'hC704_DD7B);

        repeat (3) @(negedge clk);
        check("reset o_SIG",       bus_a.o_SIG, 32'h0);
        check("reset o_FRAME_CNT", 32'(bus_a.o_FRAME_CNT), 32'h0);
        check("reset o_BUSY",      32'(bus_a.o_BUSY), 32'h0);
        rst_n = 1'b1;

        drive_frame(0, V_SPAN);
        drive_frame(0, V_SPAN);
        check("no report while skipping", 32'(rep_sig.size()), 32'd0);
        drive_frame(0, V_SPAN);
        check("first report count", 32'(rep_sig.size()), 32'd1);
        check("first report pix",   rep_pix[0],   32'd128);
        check("first report frame", rep_frame[0], 32'd1);
        check("first report seq",   rep_seq[0],   32'd0);
        zero_sig = rep_sig[0];
        check("1x1 report count", 32'(b_reps), 32'd3);
        check("1x1 sig",          b_last_sig, 32'hC704_DD7B);
        check("1x1 pix",          b_last_pix, 32'd1);

        base = rep_sig.size();
        for (int f = 0; f < 4; f++) drive_frame(1, V_SPAN);
        check("ramp report count", 32'(rep_sig.size() - base), 32'd4);
        ramp_sig = rep_sig[base];
        check_ne("ramp differs from zeros", ramp_sig, zero_sig);
        for (int f = 0; f < 4; f++) begin
            check("ramp sig stable", rep_sig[base + f], ramp_sig);
            check("ramp frame cnt",  rep_frame[base + f], 32'(2 + f));
        end

        base = rep_sig.size();
        drive_frame(2, V_SPAN);
        drive_frame(1, V_SPAN);
        check_ne("flipped frame sig", rep_sig[base], ramp_sig);
        check("frame after flip",    rep_sig[base + 1], ramp_sig);

        base = rep_sig.size();
        check("seq clear before skip", 32'(bus_a.o_SEQ_ERR), 32'd0);
        drive_frame(3, V_SPAN);
        check("seq frame reported", 32'(rep_sig.size() - base), 32'd1);
        check("seq frame pix",      rep_pix[base], 32'd127);
        check("seq flag set",       rep_seq[base], 32'd1);

        drive_frame(1, 9);
        check("busy mid frame", 32'(bus_a.o_BUSY), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check("mid reset o_SIG",       bus_a.o_SIG, 32'h0);
        check("mid reset o_PIX_CNT",   bus_a.o_PIX_CNT, 32'h0);
        check("mid reset o_FRAME_CNT", 32'(bus_a.o_FRAME_CNT), 32'h0);
        check("mid reset o_SEQ_ERR",   32'(bus_a.o_SEQ_ERR), 32'h0);
        check("mid reset o_BUSY",      32'(bus_a.o_BUSY), 32'h0);
        rst_n = 1'b1;
        base = rep_sig.size();
        drive_frame(1, V_SPAN);
        drive_frame(1, V_SPAN);
        check("no report after reset skip", 32'(rep_sig.size() - base), 32'd0);
        drive_frame(1, V_SPAN);
        check("report after reset", 32'(rep_sig.size() - base), 32'd1);
        check("post reset frame",   rep_frame[base], 32'd1);
        check("post reset sig",     rep_sig[base], ramp_sig);

        base = rep_sig.size();
        drive_frame(1, 7);
        check("seq clear before restart", 32'(bus_a.o_SEQ_ERR), 32'd0);
        drive_frame(1, V_SPAN);
        check("restart report count", 32'(rep_sig.size() - base), 32'd1);
        check("restart pix",          rep_pix[base], 32'd128);
        check("restart sig",          rep_sig[base], ramp_sig);
        check("restart seq",          32'(bus_a.o_SEQ_ERR), 32'd1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
